keypad_key_controller: RTL

Sequencing controller that sits between keypad_scanner and the display path. It watches the scanner's synchronized column/row outputs and freezes the scan on a detected row. It debounces press and release, then emits exactly one decoded hex key code per physical press. It also maintains the two most recent keys for the dual seven-segment display.

---
 rtl/keypad_pkg.sv | 14 +
 rtl/keypad_decode.sv | 21 ++
 rtl/keypad_key_controller.sv | 101 ++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, key map and helpers for the keypad controller
package keypad_pkg;
  typedef enum logic [2:0] {IDLE, DEBOUNCE, ACCEPT, HELD, RELEASE} state_t;
  localparam logic [3:0] COLS_IDLE = 4'b1111;
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };
  function automatic logic onehot4_valid(input logic [3:0] v);
    return $countones(v) == 1;
  endfunction
endpackage

// File: rtl/keypad_decode.sv
// keypad_decode: one-hot row plus active-low column to hex key code and validity
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [3:0] row_idx,
  input  logic [3:0] col_sync,
  output logic       valid,
  output logic [3:0] code
);
  logic [1:0] r, c;
  always_comb begin
    r = 2'd0;
    c = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row_idx[i]) r = 2'(i);
      if (!col_sync[i]) c = 2'(i);
    end
  end
  assign valid = onehot4_valid(row_idx) && onehot4_valid(~col_sync);
  assign code  = KEY_MAP[r][c];
endmodule

// File: rtl/keypad_key_controller.sv
// keypad_key_controller: freezes the scan on a press, debounces press and release,
// and emits one decoded key per physical press while tracking the last two keys
module keypad_key_controller
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_idx,
  input  logic [3:0] col_sync,
  input  logic       key_detected,
  output logic       scan_hold,
  output logic [3:0] key_code,
  output logic       key_pulse,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       busy
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0] cand_row, cand_row_d, cand_col, cand_col_d;
  logic [3:0] code_d, new_d, old_d, dec_code;
  logic pulse_d, dec_valid;
  // Idle qualifies live inputs; afterwards the latched candidate is decoded
  keypad_decode u_dec (
    .row_idx (state == IDLE ? row_idx : cand_row),
    .col_sync(state == IDLE ? col_sync : cand_col),
    .valid   (dec_valid),
    .code    (dec_code)
  );
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    cand_row_d = cand_row;
    cand_col_d = cand_col;
    pulse_d    = 1'b0;
    code_d     = key_code;
    new_d      = digit_new;
    old_d      = digit_old;
    case (state)
      IDLE:
        if (key_detected && dec_valid) begin
          cand_row_d = row_idx;
          cand_col_d = col_sync;
          cnt_d      = '0;
          state_d    = DEBOUNCE;
        end
      DEBOUNCE:
        if (col_sync != cand_col) state_d = IDLE;
        else if (cnt == LAST) state_d = ACCEPT;
        else cnt_d = cnt + 1'b1;
      ACCEPT: begin
        pulse_d = 1'b1;
        code_d  = dec_code;
        new_d   = dec_code;
        old_d   = digit_new;
        state_d = HELD;
      end
      HELD:
        if (col_sync == COLS_IDLE) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      RELEASE:
        if (col_sync != COLS_IDLE) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt == LAST) state_d = IDLE;
        else cnt_d = cnt + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cand_row  <= '0;
      cand_col  <= '0;
      scan_hold <= 1'b0;
      busy      <= 1'b0;
      key_pulse <= 1'b0;
      key_code  <= '0;
      digit_new <= '0;
      digit_old <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cand_row  <= cand_row_d;
      cand_col  <= cand_col_d;
      scan_hold <= state_d != IDLE;
      busy      <= state_d != IDLE;
      key_pulse <= pulse_d;
      key_code  <= code_d;
      digit_new <= new_d;
      digit_old <= old_d;
    end
  end
endmodule
